// File: rtl/gg_dma_wrmb_if.sv
// -----------------------------------------------------------------------------
// gg_dma_wrmb_if
//   Bundles every handshake bus of the macroblock write DMA:
//     - AXI-Lite 32-bit control/status slave (s_ar*/s_r*/s_aw*/s_w*/s_b*)
//     - AXI4 128-bit write master             (m_aw*/m_w*/m_b*)
//     - 128-bit pel stream input              (s_valid/s_ready/s_data/s_last)
//   Modports:
//     slave  : the DMA block's view (AXI-L slave, AXI4 master, stream sink)
//     master : the surrounding system's view (CPU, memory, stream source)
// -----------------------------------------------------------------------------
interface gg_dma_wrmb_if;
    // AXI-Lite control slave
    logic         s_arvalid;
    logic         s_arready;
    logic [7:0]   s_araddr;
    logic         s_rvalid;
    logic         s_rready;
    logic [31:0]  s_rdata;
    logic [1:0]   s_rresp;
    logic         s_awvalid;
    logic         s_awready;
    logic [7:0]   s_awaddr;
    logic         s_wvalid;
    logic         s_wready;
    logic [31:0]  s_wdata;
    logic         s_bvalid;
    logic         s_bready;
    logic [1:0]   s_bresp;
    // AXI4 write master
    logic         m_awvalid;
    logic         m_awready;
    logic [39:0]  m_awaddr;
    logic [7:0]   m_awlen;
    logic [2:0]   m_awsize;
    logic [1:0]   m_awburst;
    logic [3:0]   m_awcache;
    logic         m_wvalid;
    logic         m_wready;
    logic [127:0] m_wdata;
    logic [15:0]  m_wstrb;
    logic         m_wlast;
    logic         m_bvalid;
    logic         m_bready;
    logic [1:0]   m_bresp;
    // pel stream input
    logic         s_valid;
    logic         s_ready;
    logic [127:0] s_data;
    logic         s_last;

    modport slave (
        input  s_arvalid, s_araddr, s_rready, s_awvalid, s_awaddr, s_wvalid, s_wdata, s_bready,
        output s_arready, s_rvalid, s_rdata, s_rresp, s_awready, s_wready, s_bvalid, s_bresp,
        output m_awvalid, m_awaddr, m_awlen, m_awsize, m_awburst, m_awcache,
        output m_wvalid, m_wdata, m_wstrb, m_wlast, m_bready,
        input  m_awready, m_wready, m_bvalid, m_bresp,
        input  s_valid, s_data, s_last,
        output s_ready
    );

    modport master (
        output s_arvalid, s_araddr, s_rready, s_awvalid, s_awaddr, s_wvalid, s_wdata, s_bready,
        input  s_arready, s_rvalid, s_rdata, s_rresp, s_awready, s_wready, s_bvalid, s_bresp,
        input  m_awvalid, m_awaddr, m_awlen, m_awsize, m_awburst, m_awcache,
        input  m_wvalid, m_wdata, m_wstrb, m_wlast, m_bready,
        output m_awready, m_wready, m_bvalid, m_bresp,
        output s_valid, s_data, s_last,
        input  s_ready
    );
endinterface

// File: rtl/gg_dma_wrmb.sv
// -----------------------------------------------------------------------------
// gg_dma_wrmb -- macroblock write DMA
//   Takes the reconstructed 4x4-block stream (MB_BEATS 128-bit beats per MB,
//   last beat tagged s_last), buffers it in a FIFO and writes it to a DRAM ring
//   buffer [base, limit) as BURST_BEATS-beat AXI4 INCR bursts. Software
//   controls it through a small AXI-Lite register file.
//
//   Ports
//     clk      clock
//     reset_n  asynchronous active-low reset
//     bus      gg_dma_wrmb_if.slave: AXI-L slave, AXI4 write master, stream in
//
//   Register map (AXI-L, 32-bit)
//     0x00 ctrl   b0 go RW, b1 bresp_err W1C, b2 sync_err W1C, b3 busy RO
//     0x08/0x0C   base  [31:0]/[39:32]  (bits[6:0] read as 0)
//     0x10/0x14   limit [31:0]/[39:32]  (bits[6:0] read as 0)
//     0x20/0x24   write_addr; writable only while go=0 and not busy
//     0x28        mb_done count (wraps)
//     other       read 32'hdead_beef, writes ignored
//
//   Build option
//     GG_DMA_WRMB_STRIP_DC_EN : input carries two chroma DC beats after every
//     s_last beat; they are accepted and dropped before the FIFO.
// -----------------------------------------------------------------------------
module gg_dma_wrmb #(
    parameter int FIFO_DEPTH  = 32,   // power of two, >= 2*BURST_BEATS
    parameter int BURST_BEATS = 8,    // >= 2
    parameter int MB_BEATS    = 24,   // multiple of BURST_BEATS
    parameter int MAX_OUTST   = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    gg_dma_wrmb_if.slave bus
);
    localparam int FA_W   = $clog2(FIFO_DEPTH);
    localparam int FC_W   = $clog2(FIFO_DEPTH + 1);
    localparam int PEND_W = $clog2(MAX_OUTST * BURST_BEATS + 1);
    localparam int OST_W  = $clog2(MAX_OUTST + 1);
    localparam int BB_W   = $clog2(BURST_BEATS);
    localparam int MB_W   = $clog2(MB_BEATS);
    localparam int MBB    = MB_BEATS / BURST_BEATS;
    localparam int MBB_W  = $clog2(MBB + 1);

    typedef enum logic       {RD_IDLE, RD_DATA} rd_state_e;
    typedef enum logic [1:0] {WR_IDLE, WR_WRITE, WR_RESP} wr_state_e;

    // ---------------------------------------------------------------- state
    logic                 rst_done_q;
    logic                 go_q, berr_q, serr_q;
    logic [39:0]          base_q, limit_q, wa_q;
    logic [31:0]          mb_done_q, mb_done_d;
    logic [FA_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FC_W-1:0]      cnt_q, cnt_d;
    logic [MB_W-1:0]      beat_q, beat_d;
    logic [PEND_W-1:0]    w_pend_q, w_pend_d;
    logic [BB_W-1:0]      wbeat_q, wbeat_d;
    logic                 aw_vld_q, aw_vld_d;
    logic [OST_W-1:0]     outst_q, outst_d;
    logic [MBB_W-1:0]     bcnt_q, bcnt_d;
    logic [31:0]          rdata_q;
    rd_state_e            rd_state_q, rd_state_d;
    wr_state_e            wr_state_q, wr_state_d;
    logic [127:0]         mem_q [FIFO_DEPTH];

    // ---------------------------------------------------------------- comb
    logic                 s_fire, drop, push;
    logic                 aw_start, aw_fire, w_vld, w_fire, b_fire;
    logic                 busy, wa_wr_ok, sync_set, berr_set;
    logic [FC_W-1:0]      unclaimed;
    logic [39:0]          wa_next, wa_adv;
    logic                 ar_rdy, r_vld, aw_rdy, b_vld, reg_we;
    logic [31:0]          rd_mux;

    // ---------------------------------------------------------------- stream in
    assign bus.s_ready = rst_done_q & (cnt_q != FC_W'(FIFO_DEPTH));
    assign s_fire      = bus.s_valid & bus.s_ready;

`ifdef GG_DMA_WRMB_STRIP_DC_EN
    // Count of chroma DC beats still to be swallowed after an s_last beat.
    logic [1:0] dc_left_q, dc_left_d;
    assign drop = (dc_left_q != 2'd0);

    always_comb begin
        dc_left_d = dc_left_q;
        if (s_fire) begin
            if (drop)             dc_left_d = dc_left_q - 2'd1;
            else if (bus.s_last)  dc_left_d = 2'd2;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) dc_left_q <= 2'd0;
        else          dc_left_q <= dc_left_d;
    end
`else
    assign drop = 1'b0;
`endif

    assign push = s_fire & ~drop;

    // FIFO storage carries no reset: contents are only observed behind cnt_q.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= bus.s_data;
    end

    // ---------------------------------------------------------------- AXI4 write
    // Words already promised to an issued burst are not available for a new AW.
    assign unclaimed = cnt_q - FC_W'(w_pend_q);
    assign aw_start  = go_q & ~aw_vld_q & (unclaimed >= FC_W'(BURST_BEATS))
                     & (outst_q < OST_W'(MAX_OUTST));
    assign aw_fire   = aw_vld_q & bus.m_awready;
    // W may go in the same cycle its AW handshakes, never earlier.
    assign w_vld     = rst_done_q & ((w_pend_q != '0) | aw_fire);
    assign w_fire    = w_vld & bus.m_wready;
    assign b_fire    = bus.m_bvalid & rst_done_q;

    assign busy      = (outst_q != '0) | (w_pend_q != '0) | aw_vld_q;
    assign wa_wr_ok  = ~go_q & ~busy;
    assign wa_next   = wa_q + 40'(BURST_BEATS * 16);
    assign wa_adv    = (wa_next >= limit_q) ? base_q : wa_next;

    assign bus.m_awvalid = aw_vld_q;
    assign bus.m_awaddr  = wa_q;
    assign bus.m_awlen   = 8'(BURST_BEATS - 1);
    assign bus.m_awsize  = 3'b100;
    assign bus.m_awburst = 2'b01;
    assign bus.m_awcache = 4'b0011;
    assign bus.m_wvalid  = w_vld;
    assign bus.m_wdata   = mem_q[rd_ptr_q];
    assign bus.m_wstrb   = '1;
    assign bus.m_wlast   = (wbeat_q == BB_W'(BURST_BEATS - 1));
    assign bus.m_bready  = rst_done_q;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        cnt_d     = cnt_q + FC_W'(push) - FC_W'(w_fire);
        beat_d    = beat_q;
        sync_set  = 1'b0;
        aw_vld_d  = aw_vld_q;
        w_pend_d  = w_pend_q + (aw_fire ? PEND_W'(BURST_BEATS) : '0) - PEND_W'(w_fire);
        wbeat_d   = wbeat_q;
        outst_d   = outst_q + OST_W'(aw_fire) - OST_W'(b_fire);
        bcnt_d    = bcnt_q;
        mb_done_d = mb_done_q;
        berr_set  = 1'b0;

        if (push)
            wr_ptr_d = (wr_ptr_q == FA_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + FA_W'(1);
        if (w_fire) begin
            rd_ptr_d = (rd_ptr_q == FA_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + FA_W'(1);
            wbeat_d  = (wbeat_q == BB_W'(BURST_BEATS - 1)) ? '0 : wbeat_q + BB_W'(1);
        end

        // MB framing check: s_last must land on the final beat; resync on it.
        if (push) begin
            if (bus.s_last) begin
                sync_set = (beat_q != MB_W'(MB_BEATS - 1));
                beat_d   = '0;
            end else begin
                beat_d = (beat_q == MB_W'(MB_BEATS - 1)) ? '0 : beat_q + MB_W'(1);
            end
        end

        // AW stays up, address unchanged, until the handshake.
        if (aw_fire)       aw_vld_d = 1'b0;
        else if (aw_start) aw_vld_d = 1'b1;

        if (b_fire) begin
            berr_set = (bus.m_bresp != 2'b00);
            if (bcnt_q == MBB_W'(MBB - 1)) begin
                bcnt_d    = '0;
                mb_done_d = mb_done_q + 32'd1;
            end else begin
                bcnt_d = bcnt_q + MBB_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_done_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            beat_q     <= '0;
            aw_vld_q   <= 1'b0;
            w_pend_q   <= '0;
            wbeat_q    <= '0;
            outst_q    <= '0;
            bcnt_q     <= '0;
            mb_done_q  <= '0;
        end else begin
            rst_done_q <= 1'b1;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            beat_q     <= beat_d;
            aw_vld_q   <= aw_vld_d;
            w_pend_q   <= w_pend_d;
            wbeat_q    <= wbeat_d;
            outst_q    <= outst_d;
            bcnt_q     <= bcnt_d;
            mb_done_q  <= mb_done_d;
        end
    end

    // ---------------------------------------------------------------- AXI-L read FSM
    always_comb begin
        rd_mux = 32'hdead_beef;
        case (bus.s_araddr)
            8'h00:   rd_mux = {28'd0, busy, serr_q, berr_q, go_q};
            8'h08:   rd_mux = base_q[31:0];
            8'h0C:   rd_mux = {24'd0, base_q[39:32]};
            8'h10:   rd_mux = limit_q[31:0];
            8'h14:   rd_mux = {24'd0, limit_q[39:32]};
            8'h20:   rd_mux = wa_q[31:0];
            8'h24:   rd_mux = {24'd0, wa_q[39:32]};
            8'h28:   rd_mux = mb_done_q;
            default: rd_mux = 32'hdead_beef;
        endcase
    end

    always_comb begin
        rd_state_d = rd_state_q;
        ar_rdy     = 1'b0;
        r_vld      = 1'b0;
        case (rd_state_q)
            RD_IDLE: begin
                ar_rdy = rst_done_q;
                if (bus.s_arvalid & rst_done_q) rd_state_d = RD_DATA;
            end
            RD_DATA: begin
                r_vld = 1'b1;
                if (bus.s_rready) rd_state_d = RD_IDLE;
            end
            default: rd_state_d = RD_IDLE;
        endcase
    end

    // Read data is captured at the address phase so R stays stable while stalled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_state_q <= RD_IDLE;
            rdata_q    <= '0;
        end else begin
            rd_state_q <= rd_state_d;
            if (ar_rdy & bus.s_arvalid) rdata_q <= rd_mux;
        end
    end

    assign bus.s_arready = ar_rdy;
    assign bus.s_rvalid  = r_vld;
    assign bus.s_rdata   = rdata_q;
    assign bus.s_rresp   = 2'b00;

    // ---------------------------------------------------------------- AXI-L write FSM
    always_comb begin
        wr_state_d = wr_state_q;
        aw_rdy     = 1'b0;
        b_vld      = 1'b0;
        reg_we     = 1'b0;
        case (wr_state_q)
            WR_IDLE: begin
                if (bus.s_awvalid & bus.s_wvalid & rst_done_q) wr_state_d = WR_WRITE;
            end
            WR_WRITE: begin
                aw_rdy     = 1'b1;
                reg_we     = 1'b1;
                wr_state_d = WR_RESP;
            end
            WR_RESP: begin
                b_vld = 1'b1;
                if (bus.s_bready) wr_state_d = WR_IDLE;
            end
            default: wr_state_d = WR_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) wr_state_q <= WR_IDLE;
        else          wr_state_q <= wr_state_d;
    end

    assign bus.s_awready = aw_rdy;
    assign bus.s_wready  = aw_rdy;
    assign bus.s_bvalid  = b_vld;
    assign bus.s_bresp   = 2'b00;

    // ---------------------------------------------------------------- registers
    // Hardware set of the sticky flags is applied after the W1C so a
    // coincident error is never lost. write_addr writes and AW advance are
    // mutually exclusive because a pending AW counts as busy.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            go_q    <= 1'b0;
            berr_q  <= 1'b0;
            serr_q  <= 1'b0;
            base_q  <= '0;
            limit_q <= '0;
            wa_q    <= '0;
        end else begin
            if (reg_we) begin
                case (bus.s_awaddr)
                    8'h00: begin
                        go_q <= bus.s_wdata[0];
                        if (bus.s_wdata[1]) berr_q <= 1'b0;
                        if (bus.s_wdata[2]) serr_q <= 1'b0;
                    end
                    8'h08: base_q[31:0]   <= {bus.s_wdata[31:7], 7'd0};
                    8'h0C: base_q[39:32]  <= bus.s_wdata[7:0];
                    8'h10: limit_q[31:0]  <= {bus.s_wdata[31:7], 7'd0};
                    8'h14: limit_q[39:32] <= bus.s_wdata[7:0];
                    8'h20: if (wa_wr_ok) wa_q[31:0]  <= bus.s_wdata;
                    8'h24: if (wa_wr_ok) wa_q[39:32] <= bus.s_wdata[7:0];
                    default: ;
                endcase
            end
            if (berr_set) berr_q <= 1'b1;
            if (sync_set) serr_q <= 1'b1;
            if (aw_fire)  wa_q   <= wa_adv;
        end
    end
endmodule

// File: tb/tb_gg_dma_wrmb.sv
`timescale 1ns/1ps
module tb_gg_dma_wrmb;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    gg_dma_wrmb_if bus();
    gg_dma_wrmb dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ------------------------------------------------ reference model
    // Ring-buffer writer: every kept beat is written in order; each group of
    // 8 kept beats becomes one burst at the next ring address.
    logic [127:0] exp_w[$];
    logic [39:0]  exp_aw[$];
    logic [39:0]  m_addr, m_base, m_limit;
    int           kept = 0;
    int           dc_left = 0;

    function automatic void model_beat(input logic [127:0] d, input logic last);
`ifdef GG_DMA_WRMB_STRIP_DC_EN
        if (dc_left > 0) begin
            dc_left--;
            return;
        end
        if (last) dc_left = 2;
`endif
        exp_w.push_back(d);
        kept++;
        if (kept % 8 == 0) begin
            exp_aw.push_back(m_addr);
            if (m_addr + 40'd128 >= m_limit) m_addr = m_base;
            else                             m_addr = m_addr + 40'd128;
        end
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ------------------------------------------------ memory-side responders
    int rdy_pct = 100;
    int bq[$];
    int err_burst = -1;

    initial begin
        bus.m_awready = 1'b0;
        bus.m_wready  = 1'b0;
        forever begin
            @(posedge clk); #1;
            bus.m_awready = ($urandom_range(99) < rdy_pct);
            bus.m_wready  = ($urandom_range(99) < rdy_pct);
        end
    end

    initial begin
        int t;
        bus.m_bvalid = 1'b0;
        bus.m_bresp  = 2'b00;
        forever begin
            @(posedge clk); #1;
            if (bq.size() > 0) begin
                repeat ($urandom_range(3)) begin @(posedge clk); #1; end
                bus.m_bvalid = 1'b1;
                bus.m_bresp  = 2'(bq.pop_front());
                t = 0;
                do begin @(negedge clk); t++; end while (!bus.m_bready && t < 100);
                if (!bus.m_bready) begin
                    checks++; errors++;
                    $display("FAIL b_handshake: bready never seen");
                end
                @(posedge clk); #1;
                bus.m_bvalid = 1'b0;
            end
        end
    end

    // ------------------------------------------------ monitor / scoreboard
    int          outst = 0, wbeat = 0, bursts = 0, aw_fires = 0, w_allow = 0;
    logic        aw_hold = 1'b0;
    logic [39:0] aw_hold_addr;

    always @(negedge clk) begin
        if (reset_n) begin
            if (aw_hold) begin
                chk("awvalid_held", bus.m_awvalid, 1'b1);
                chk("awaddr_stable", bus.m_awaddr, aw_hold_addr);
            end
            aw_hold      = bus.m_awvalid & ~bus.m_awready;
            aw_hold_addr = bus.m_awaddr;
            if (bus.m_awvalid && bus.m_awready) begin
                aw_fires++;
                outst++;
                w_allow += 8;
                if (exp_aw.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL aw_unexpected: got %0h expected none", bus.m_awaddr);
                end else chk("aw_addr", bus.m_awaddr, exp_aw.pop_front());
                chk("aw_len", bus.m_awlen, 8'd7);
                chk("outstanding_le_2", outst <= 2, 1'b1);
            end
            if (bus.m_wvalid && bus.m_wready) begin
                chk("w_after_aw", w_allow > 0, 1'b1);
                w_allow--;
                if (exp_w.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL w_unexpected: got %0h expected none", bus.m_wdata);
                end else chk("w_data", bus.m_wdata, exp_w.pop_front());
                chk("w_last", bus.m_wlast, wbeat == 7);
                if (wbeat == 7) begin
                    bq.push_back((bursts == err_burst) ? 2 : 0);
                    bursts++;
                    wbeat = 0;
                end else wbeat++;
            end
            if (bus.m_bvalid && bus.m_bready) outst--;
        end
    end

    // ------------------------------------------------ stimulus tasks
    task automatic send_beat(input logic [127:0] d, input logic last, input int gap_pct);
        int t = 0;
        while ($urandom_range(99) < gap_pct) begin @(posedge clk); #1; end
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        bus.s_last  = last;
        do begin @(negedge clk); t++; end while (!bus.s_ready && t < 1000);
        if (!bus.s_ready) begin
            checks++; errors++;
            $display("FAIL s_ready_timeout: got 0 expected 1");
        end else model_beat(d, last);
        @(posedge clk); #1;
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    task automatic send_dc(input int gap_pct);
`ifdef GG_DMA_WRMB_STRIP_DC_EN
        send_beat(128'hdc00, 1'b0, gap_pct);
        send_beat(128'hdc01, 1'b0, gap_pct);
`endif
    endtask

    task automatic send_mb(input int gap_pct);
        for (int i = 0; i < 24; i++) send_beat(rnd128(), i == 23, gap_pct);
        send_dc(gap_pct);
    endtask

    task automatic axil_wr(input logic [7:0] a, input logic [31:0] d);
        int t = 0;
        bus.s_awvalid = 1'b1; bus.s_awaddr = a;
        bus.s_wvalid  = 1'b1; bus.s_wdata  = d;
        do begin @(negedge clk); t++; end while (!(bus.s_awready && bus.s_wready) && t < 100);
        if (t >= 100) begin
            checks++; errors++;
            $display("FAIL axil_aw_timeout: addr %0h", a);
        end
        @(posedge clk); #1;
        bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b0; bus.s_bready = 1'b1;
        t = 0;
        do begin @(negedge clk); t++; end while (!bus.s_bvalid && t < 100);
        chk("axil_bvalid", bus.s_bvalid, 1'b1);
        @(posedge clk); #1;
        bus.s_bready = 1'b0;
    endtask

    task automatic axil_rd(input logic [7:0] a, output logic [31:0] d);
        int t = 0;
        bus.s_arvalid = 1'b1; bus.s_araddr = a;
        do begin @(negedge clk); t++; end while (!bus.s_arready && t < 100);
        @(posedge clk); #1;
        bus.s_arvalid = 1'b0; bus.s_rready = 1'b1;
        t = 0;
        do begin @(negedge clk); t++; end while (!bus.s_rvalid && t < 100);
        if (!bus.s_rvalid) begin
            checks++; errors++;
            $display("FAIL axil_r_timeout: addr %0h", a);
        end
        d = bus.s_rdata;
        @(posedge clk); #1;
        bus.s_rready = 1'b0;
    endtask

    task automatic rd_chk(input string nm, input logic [7:0] a, input logic [31:0] exp);
        logic [31:0] d;
        axil_rd(a, d);
        chk(nm, d, exp);
    endtask

    task automatic wait_drain();
        int t = 0;
        while ((exp_aw.size() != 0 || outst != 0 || bq.size() != 0 || bus.m_bvalid) && t < 20000) begin
            @(negedge clk); t++;
        end
        chk("drain_in_time", t < 20000, 1'b1);
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic config_ring(input logic [39:0] b, input logic [39:0] l, input logic [39:0] w);
        axil_wr(8'h00, 32'h0);
        axil_wr(8'h08, b[31:0]);  axil_wr(8'h0C, {24'd0, b[39:32]});
        axil_wr(8'h10, l[31:0]);  axil_wr(8'h14, {24'd0, l[39:32]});
        axil_wr(8'h20, w[31:0]);  axil_wr(8'h24, {24'd0, w[39:32]});
        m_base = b; m_limit = l; m_addr = w;
        axil_wr(8'h00, 32'h1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ------------------------------------------------ main sequence
    initial begin
        int snap;
        bus.s_arvalid = 0; bus.s_araddr = 0; bus.s_rready = 0;
        bus.s_awvalid = 0; bus.s_awaddr = 0; bus.s_wvalid = 0; bus.s_wdata = 0; bus.s_bready = 0;
        bus.s_valid = 0; bus.s_data = 0; bus.s_last = 0;

        repeat (3) @(negedge clk);
        chk("reset_outputs", {bus.s_ready, bus.m_awvalid, bus.m_wvalid, bus.s_bvalid,
                              bus.s_rvalid, bus.s_arready, bus.m_bready}, 7'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        rd_chk("ctrl_reset", 8'h00, 32'h0);
        rd_chk("mb_done_reset", 8'h28, 32'h0);
        rd_chk("unmapped_read", 8'h04, 32'hdead_beef);
        axil_wr(8'h08, 32'h0001_2345);
        rd_chk("base_low_bits_forced", 8'h08, 32'h0001_2300);

        // single MB into a large ring
        config_ring(40'h1000, 40'h10000, 40'h1000);
        send_mb(0);
        wait_drain();
        rd_chk("t1_mb_done", 8'h28, 32'd1);
        rd_chk("t1_write_addr", 8'h20, 32'h1180);
        axil_wr(8'h20, 32'h5000);
        rd_chk("wa_locked_while_go", 8'h20, 32'h1180);

        // three MBs into a 6-burst ring: third MB wraps to base
        config_ring(40'h0, 40'h300, 40'h0);
        for (int m = 0; m < 3; m++) send_mb(0);
        wait_drain();
        rd_chk("t2_write_addr", 8'h20, 32'h180);
        rd_chk("t2_mb_done", 8'h28, 32'd4);

        // error response on the second burst of an MB
        err_burst = bursts + 1;
        send_mb(0);
        wait_drain();
        rd_chk("bresp_err_set", 8'h00, 32'h3);
        axil_wr(8'h00, 32'h3);
        rd_chk("bresp_err_w1c", 8'h00, 32'h1);

        // go dropped after beat 10: first burst completes, no second AW
        config_ring(40'h1000, 40'h10000, 40'h1000);
        for (int i = 0; i < 10; i++) send_beat(rnd128(), 1'b0, 0);
        wait_drain();
        axil_wr(8'h00, 32'h0);
        snap = aw_fires;
        for (int i = 10; i < 24; i++) send_beat(rnd128(), i == 23, 0);
        send_dc(0);
        repeat (50) @(posedge clk);
        #1;
        chk("no_aw_while_stopped", aw_fires, snap);
        rd_chk("stopped_not_busy", 8'h00, 32'h0);
        rd_chk("stopped_write_addr", 8'h20, 32'h1080);
        axil_wr(8'h00, 32'h1);
        wait_drain();
        rd_chk("t5_mb_done", 8'h28, 32'd6);

        // random stalls, 64 MBs into a 16-burst ring
        config_ring(40'h2000, 40'h2800, 40'h2400);
        rdy_pct = 60;
        for (int m = 0; m < 64; m++) send_mb(30);
        wait_drain();
        rdy_pct = 100;
        rd_chk("t3_mb_done", 8'h28, 32'd70);
        chk("t3_all_data_written", exp_w.size(), 0);

        // s_last on beat 20 flags a framing error; data still written
        for (int i = 0; i < 21; i++) send_beat(rnd128(), i == 20, 0);
        send_dc(0);
        for (int i = 0; i < 3; i++) send_beat(rnd128(), 1'b0, 0);
        wait_drain();
        rd_chk("sync_err_set", 8'h00, 32'h5);
        axil_wr(8'h00, 32'h5);
        rd_chk("sync_err_w1c", 8'h00, 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
